// File: rtl/sim_mon_pkg.sv
// Shared encodings for the reset-sequencer / run monitor: FSM states and
// the end-of-run status codes reported on the status port.
package sim_mon_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SEQ  = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ST_RUNNING = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sim_mon_rst_seq.sv
// Reset release sequencer: waits RST_HOLD edges, then releases each
// rst_out_b bit RST_GAP edges after the previous one. Bits never re-assert.
module sim_mon_rst_seq
  import sim_mon_pkg::*;
#(
  parameter int NUM_RST  = 3,
  parameter int RST_HOLD = 16,
  parameter int RST_GAP  = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  output logic [NUM_RST-1:0] rst_out_b,
  output logic               hold_done,
  output logic               seq_done
);

  localparam int STEP_W = $clog2(max2(RST_HOLD, RST_GAP) + 1);
  localparam int IDX_W  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  logic [STEP_W-1:0]  step_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_RST-1:0] rel_q;
  logic               fire;

  // fire marks the edge that releases bit idx_q; the top FSM moves on the same edge.
  assign fire      = (step_q == '0) && !rel_q[NUM_RST-1];
  assign hold_done = fire && (idx_q == '0);
  assign seq_done  = fire && (idx_q == IDX_W'(NUM_RST - 1));
  assign rst_out_b = rel_q;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      step_q <= STEP_W'(RST_HOLD - 1);
      idx_q  <= '0;
      rel_q  <= '0;
    end else if (!rel_q[NUM_RST-1]) begin
      if (step_q == '0) begin
        rel_q  <= rel_q | (NUM_RST'(1) << idx_q);
        step_q <= STEP_W'(RST_GAP - 1);
        idx_q  <= idx_q + 1'b1;
      end else begin
        step_q <= step_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_rst_seq_monitor.sv
// Reset sequencer plus run monitor: counts RUN cycles, ends on a mailbox
// PASS/FAIL write or timeout. Define SIM_MON_HEARTBEAT_EN to build hb_pulse.
module sim_rst_seq_monitor
  import sim_mon_pkg::*;
#(
  parameter int          NUM_RST   = 3,
  parameter int          RST_HOLD  = 16,
  parameter int          RST_GAP   = 4,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] MBOX_ADDR = 32'h2000_FFF0,
  parameter logic [31:0] PASS_CODE = 32'h0000_600D,
  parameter logic [31:0] FAIL_CODE = 32'h0000_BAD0,
  parameter int          HB_SHIFT  = 16
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [CNT_W-1:0]   timeout_cyc,
  input  logic               bus_wr_vld,
  input  logic [31:0]        bus_wr_addr,
  input  logic [31:0]        bus_wr_data,
  output logic [NUM_RST-1:0] rst_out_b,
  output logic [CNT_W-1:0]   run_cnt,
  output logic               done,
  output logic [1:0]         status,
  output logic               hb_pulse
);

  state_e           state_q;
  status_e          status_q;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] run_inc;
  logic             done_q;
  logic             hold_done, seq_done;
  logic             mbox_sel, pass_hit, fail_hit, tmo_hit;

  sim_mon_rst_seq #(
    .NUM_RST  (NUM_RST),
    .RST_HOLD (RST_HOLD),
    .RST_GAP  (RST_GAP)
  ) u_rst_seq (
    .clk       (clk),
    .rst_b     (rst_b),
    .rst_out_b (rst_out_b),
    .hold_done (hold_done),
    .seq_done  (seq_done)
  );

  assign run_inc  = (run_q == '1) ? run_q : run_q + 1'b1;
  assign mbox_sel = bus_wr_vld && (bus_wr_addr == MBOX_ADDR);
  assign pass_hit = mbox_sel && (bus_wr_data == PASS_CODE);
  assign fail_hit = mbox_sel && (bus_wr_data == FAIL_CODE);
  // A saturated counter has passed any non-zero limit, including one lowered below it.
  assign tmo_hit  = (timeout_cyc != '0) && ((run_inc == timeout_cyc) || (run_q == '1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= HOLD;
      status_q <= ST_RUNNING;
      run_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (seq_done)       state_q <= RUN;
          else if (hold_done) state_q <= SEQ;
        end
        SEQ: if (seq_done) state_q <= RUN;
        RUN: begin
          if (pass_hit || fail_hit) begin
            run_q    <= run_inc;
            status_q <= pass_hit ? ST_PASS : ST_FAIL;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (tmo_hit) begin
            run_q    <= timeout_cyc;
            status_q <= ST_TIMEOUT;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            run_q <= run_inc;
          end
        end
        DONE: ;
        default: state_q <= HOLD;
      endcase
    end
  end

  assign run_cnt = run_q;
  assign done    = done_q;
  assign status  = status_q;

`ifdef SIM_MON_HEARTBEAT_EN
  logic hb_q;

  // Registered from next-cycle values so the pulse lines up with run_cnt.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hb_q <= 1'b0;
    end else begin
      hb_q <= (state_q == RUN) && !pass_hit && !fail_hit && !tmo_hit &&
              (run_inc != run_q) && (&run_inc[HB_SHIFT-1:0]);
    end
  end

  assign hb_pulse = hb_q;
`else
  assign hb_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_sim_rst_seq_monitor.sv
// Self-checking bench for sim_rst_seq_monitor: edge-count reference model
// compared every cycle, plus directed literal checks of the key events.
module tb_sim_rst_seq_monitor;

  localparam int          NUM_RST   = 3;
  localparam int          RST_HOLD  = 16;
  localparam int          RST_GAP   = 4;
  localparam int          CNT_W     = 32;
  localparam int          HB_SHIFT  = 4;
  localparam int          RUN_EDGE  = RST_HOLD + (NUM_RST - 1) * RST_GAP;
  localparam logic [31:0] MBOX      = 32'h2000_FFF0;
  localparam logic [31:0] CODE_PASS = 32'h0000_600D;
  localparam logic [31:0] CODE_FAIL = 32'h0000_BAD0;

  logic               clk;
  logic               rst_b;
  logic [CNT_W-1:0]   timeout_cyc;
  logic               bus_wr_vld;
  logic [31:0]        bus_wr_addr;
  logic [31:0]        bus_wr_data;
  logic [NUM_RST-1:0] rst_out_b;
  logic [CNT_W-1:0]   run_cnt;
  logic               done;
  logic [1:0]         status;
  logic               hb_pulse;

  sim_rst_seq_monitor #(
    .NUM_RST  (NUM_RST),
    .RST_HOLD (RST_HOLD),
    .RST_GAP  (RST_GAP),
    .CNT_W    (CNT_W),
    .HB_SHIFT (HB_SHIFT)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .timeout_cyc (timeout_cyc),
    .bus_wr_vld  (bus_wr_vld),
    .bus_wr_addr (bus_wr_addr),
    .bus_wr_data (bus_wr_data),
    .rst_out_b   (rst_out_b),
    .run_cnt     (run_cnt),
    .done        (done),
    .status      (status),
    .hb_pulse    (hb_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset release, plus the run outcome.
  int          m_edges = 0;
  logic [31:0] m_cnt   = '0;
  bit          m_done  = 1'b0;
  logic [1:0]  m_st    = 2'b00;

  initial begin
    logic [31:0] nxt;
    forever begin
      @(posedge clk or negedge rst_b);
      if (!rst_b) begin
        m_edges = 0;
        m_cnt   = '0;
        m_done  = 1'b0;
        m_st    = 2'b00;
      end else if (!m_done) begin
        if (m_edges >= RUN_EDGE) begin
          nxt = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
          if (bus_wr_vld && bus_wr_addr == MBOX && bus_wr_data == CODE_PASS) begin
            m_cnt = nxt; m_done = 1'b1; m_st = 2'b01;
          end else if (bus_wr_vld && bus_wr_addr == MBOX && bus_wr_data == CODE_FAIL) begin
            m_cnt = nxt; m_done = 1'b1; m_st = 2'b10;
          end else if (timeout_cyc != 0 && (nxt == timeout_cyc || m_cnt == 32'hFFFF_FFFF)) begin
            m_cnt = timeout_cyc; m_done = 1'b1; m_st = 2'b11;
          end else begin
            m_cnt = nxt;
          end
        end
        m_edges++;
      end
    end
  end

  function automatic logic [NUM_RST-1:0] exp_rst();
    logic [NUM_RST-1:0] r;
    for (int i = 0; i < NUM_RST; i++) r[i] = (m_edges >= RST_HOLD + i * RST_GAP);
    return r;
  endfunction

  function automatic logic exp_hb();
`ifdef SIM_MON_HEARTBEAT_EN
    return (m_edges >= RUN_EDGE) && !m_done &&
           ((m_cnt % (1 << HB_SHIFT)) == (1 << HB_SHIFT) - 1);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      check("mdl_rst_out_b", rst_out_b, exp_rst());
      check("mdl_run_cnt",   run_cnt,   m_cnt);
      check("mdl_done",      done,      m_done);
      check("mdl_status",    status,    m_st);
      check("mdl_hb_pulse",  hb_pulse,  exp_hb());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one write for the cycle ending at the next edge.
  task automatic mbox_write(input logic [31:0] addr, input logic [31:0] data);
    bus_wr_vld  = 1'b1;
    bus_wr_addr = addr;
    bus_wr_data = data;
    step(1);
    bus_wr_vld  = 1'b0;
    bus_wr_addr = '0;
    bus_wr_data = '0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst_b = 1'b0;
    #1;
    check({tag, "_rst_out_b"}, rst_out_b, 3'b000);
    check({tag, "_run_cnt"},   run_cnt,   32'd0);
    check({tag, "_done"},      done,      1'b0);
    check({tag, "_status"},    status,    2'b00);
  endtask

  initial begin
    rst_b       = 1'b1;
    timeout_cyc = '0;
    bus_wr_vld  = 1'b0;
    bus_wr_addr = '0;
    bus_wr_data = '0;
    #1 rst_b = 1'b0;
    step(3);
    check("reset_rst_out_b", rst_out_b, 3'b000);
    check("reset_run_cnt",   run_cnt,   32'd0);
    check("reset_done",      done,      1'b0);
    check("reset_status",    status,    2'b00);
    check("reset_hb",        hb_pulse,  1'b0);

    // Sequencing, filtering and mailbox PASS.
    release_rst();
    step(15); check("seq_e15", rst_out_b, 3'b000);
    step(1);  check("seq_e16", rst_out_b, 3'b001);
    step(2);  mbox_write(MBOX, CODE_FAIL);
    check("seq_fail_ignored", done, 1'b0);
    step(1);  check("seq_e20", rst_out_b, 3'b011);
    step(4);  check("seq_e24", rst_out_b, 3'b111);
    check("run_start_cnt", run_cnt, 32'd0);
    step(14); check("hb_pre", hb_pulse, 1'b0);
    step(1);  check("run_cnt_15", run_cnt, 32'd15);
`ifdef SIM_MON_HEARTBEAT_EN
    check("hb_at_15", hb_pulse, 1'b1);
`else
    check("hb_off_at_15", hb_pulse, 1'b0);
`endif
    step(1);  check("hb_at_16", hb_pulse, 1'b0);
    step(24); check("run_cnt_40", run_cnt, 32'd40);
    mbox_write(MBOX, 32'h0000_1234);
    mbox_write(32'h2000_FFF4, CODE_PASS);
    check("filter_done", done, 1'b0);
    check("filter_status", status, 2'b00);
    step(58); check("run_cnt_100", run_cnt, 32'd100);
    mbox_write(MBOX, CODE_PASS);
    check("pass_done",    done,    1'b1);
    check("pass_status",  status,  2'b01);
    check("pass_run_cnt", run_cnt, 32'd101);
    mbox_write(MBOX, CODE_FAIL);
    step(5);
    check("frozen_status",  status,  2'b01);
    check("frozen_run_cnt", run_cnt, 32'd101);
    check("frozen_rst",     rst_out_b, 3'b111);

    // Timeout at 50.
    @(negedge clk);
    pulse_reset("rstB");
    timeout_cyc = 32'd50;
    release_rst();
    step(73);
    check("tmo_pre_done", done, 1'b0);
    check("tmo_pre_cnt",  run_cnt, 32'd49);
    step(1);
    check("tmo_done",   done,    1'b1);
    check("tmo_status", status,  2'b11);
    check("tmo_cnt",    run_cnt, 32'd50);
    step(3);
    check("tmo_frozen_cnt", run_cnt, 32'd50);

    // Mailbox FAIL on the timeout edge wins.
    @(negedge clk);
    pulse_reset("rstC");
    release_rst();
    step(73);
    mbox_write(MBOX, CODE_FAIL);
    check("race_done",   done,    1'b1);
    check("race_status", status,  2'b10);
    check("race_cnt",    run_cnt, 32'd50);

    // Mid-run reset and full re-sequence.
    @(negedge clk);
    pulse_reset("rstD");
    timeout_cyc = '0;
    release_rst();
    step(54);
    check("mid_cnt_30", run_cnt, 32'd30);
    pulse_reset("mid");
    release_rst();
    step(16); check("reseq_e16", rst_out_b, 3'b001);
    step(8);  check("reseq_e24", rst_out_b, 3'b111);
    check("reseq_cnt", run_cnt, 32'd0);
    step(20);
    check("reseq_cnt_20", run_cnt, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
